// File: rtl/cpld2_sel_arbiter_pkg.sv
// Shared types and constants for the CPLD2 select-datapath arbiter.
// Holds the FSM state encoding, lane/select widths and the idle select code.
package cpld2_arb_pkg;

  localparam int unsigned N_REQ = 5;
  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] IDLE_SEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot5(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cpld2_sel_arbiter_rr_pick5.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping mod 5.
// ptr is expected to stay in 0..4.
module rr_pick5
  import cpld2_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [3:0]       sum;
  logic [SEL_W-1:0] idx;

  always_comb begin
    any = 1'b0;
    win = '0;
    sum = '0;
    idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // 4-bit sum so ptr+k (up to 8) cannot overflow before the mod-5 wrap
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
      idx = sum[SEL_W-1:0];
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/cpld2_sel_arbiter.sv
// Round-robin owner of the CPLD2 sel input: bounded hold, break-before-make gap,
// all outputs registered.
module cpld2_sel_arbiter
  import cpld2_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             active,
  output logic             timeout,
  output logic [7:0]       hold_cnt
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [3:0]       gap_cnt;
  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             owner_req;
  logic             at_limit;

  rr_pick5 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .win (pick_win)
  );

  // sel holds the owner index while in GRANT, so it doubles as the owner register
  always_comb begin
    owner_req = req[sel];
    at_limit  = (hold_cnt == 8'(MAX_HOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= IDLE_SEL;
      active   <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
      gap_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            grant    <= onehot5(pick_win);
            sel      <= pick_win;
            active   <= 1'b1;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (!owner_req || at_limit) begin
            state    <= GAP;
            grant    <= '0;
            sel      <= IDLE_SEL;
            active   <= 1'b0;
            hold_cnt <= '0;
            ptr      <= (sel == 3'd4) ? '0 : sel + 3'd1;
            timeout  <= owner_req;
            gap_cnt  <= 4'd1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES)) begin
            gap_cnt <= '0;
            if (pick_any) begin
              state    <= GRANT;
              grant    <= onehot5(pick_win);
              sel      <= pick_win;
              active   <= 1'b1;
              hold_cnt <= 8'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          sel      <= IDLE_SEL;
          active   <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpld2_sel_arbiter.sv
// Directed vector bench for cpld2_sel_arbiter (MAX_HOLD=8 and MAX_HOLD=3 instances).
module tb_cpld2_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] req3 = '0;

  logic [4:0] grant, grant3;
  logic [2:0] sel, sel3;
  logic       active, active3, timeout, timeout3;
  logic [7:0] hold_cnt, hold_cnt3;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       active;
    logic       timeout;
    logic [7:0] hold;
  } vec_t;

  vec_t tbl[$];

  cpld2_sel_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel),
    .active(active), .timeout(timeout), .hold_cnt(hold_cnt)
  );

  cpld2_sel_arbiter #(.MAX_HOLD(3), .GAP_CYCLES(1)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .grant(grant3), .sel(sel3),
    .active(active3), .timeout(timeout3), .hold_cnt(hold_cnt3)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input logic [4:0] g, input logic [2:0] s,
                                     input logic a, input logic t, input logic [7:0] h);
    return {g, s, a, t, h};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got grant=%b sel=%0d active=%b timeout=%b hold_cnt=%0d, want grant=%b sel=%0d active=%b timeout=%b hold_cnt=%0d",
               name, act[17:13], act[12:10], act[9], act[8], act[7:0],
               exp[17:13], exp[12:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic [4:0] q);
    req3 = q;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [4:0] q, input logic [4:0] g, input logic [2:0] s,
                     input logic a, input logic t, input logic [7:0] h);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.sel = s; v.active = a; v.timeout = t; v.hold = h;
    tbl.push_back(v);
  endtask

  function automatic logic [17:0] dut8_out();
    return pk(grant, sel, active, timeout, hold_cnt);
  endfunction

  function automatic logic [17:0] dut3_out();
    return pk(grant3, sel3, active3, timeout3, hold_cnt3);
  endfunction

  initial begin
    logic [17:0] idle_exp;
    logic [4:0]  oh;
    int unsigned o;
    idle_exp = pk(5'b00000, 3'd7, 1'b0, 1'b0, 8'd0);

    // single request, then ptr=3 fairness, then reset mid-grant
    add(0, 5'b00100, 5'b00100, 3'd2, 1, 0, 8'd1);
    add(0, 5'b00100, 5'b00100, 3'd2, 1, 0, 8'd2);
    add(0, 5'b00100, 5'b00100, 3'd2, 1, 0, 8'd3);
    add(0, 5'b00100, 5'b00100, 3'd2, 1, 0, 8'd4);
    add(0, 5'b00000, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b00000, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b00000, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b01000, 5'b01000, 3'd3, 1, 0, 8'd1);
    add(0, 5'b11001, 5'b01000, 3'd3, 1, 0, 8'd2);
    add(0, 5'b10001, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b10001, 5'b10000, 3'd4, 1, 0, 8'd1);
    add(0, 5'b10001, 5'b10000, 3'd4, 1, 0, 8'd2);
    add(0, 5'b00001, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b00001, 5'b00001, 3'd0, 1, 0, 8'd1);
    add(0, 5'b00001, 5'b00001, 3'd0, 1, 0, 8'd2);
    add(0, 5'b00001, 5'b00001, 3'd0, 1, 0, 8'd3);
    add(0, 5'b00001, 5'b00001, 3'd0, 1, 0, 8'd4);
    add(0, 5'b00001, 5'b00001, 3'd0, 1, 0, 8'd5);
    add(1, 5'b10001, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b10001, 5'b00001, 3'd0, 1, 0, 8'd1);
    add(0, 5'b10001, 5'b00001, 3'd0, 1, 0, 8'd2);
    add(0, 5'b10000, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b10000, 5'b10000, 3'd4, 1, 0, 8'd1);
    add(0, 5'b00000, 5'b00000, 3'd7, 0, 0, 8'd0);
    add(0, 5'b00000, 5'b00000, 3'd7, 0, 0, 8'd0);

    step(1, 5'b00000);
    check("reset0", dut8_out(), idle_exp);
    step(1, 5'b00000);
    check("reset1", dut8_out(), idle_exp);
    for (int i = 0; i < 10; i++) begin
      step(0, 5'b00000);
      check($sformatf("idle%0d", i), dut8_out(), idle_exp);
    end

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req);
      check($sformatf("tbl%0d", i), dut8_out(),
            pk(tbl[i].grant, tbl[i].sel, tbl[i].active, tbl[i].timeout, tbl[i].hold));
    end

    // all requesting: ptr is 0 here, owners rotate with a timeout at each revocation
    o = 0;
    for (int n = 0; n < 6; n++) begin
      oh = 5'd1 << o;
      for (int h = 1; h <= 8; h++) begin
        step(0, 5'b11111);
        check($sformatf("rr%0d_h%0d", n, h), dut8_out(), pk(oh, 3'(o), 1'b1, 1'b0, 8'(h)));
      end
      step(0, 5'b11111);
      check($sformatf("rr%0d_gap", n), dut8_out(), pk(5'b00000, 3'd7, 1'b0, 1'b1, 8'd0));
      o = (o + 1) % 5;
    end
    step(0, 5'b00000);
    check("rr_idle", dut8_out(), idle_exp);

    // sole requester with MAX_HOLD=3: 4-cycle period of 3 grant cycles + timeout gap
    for (int p = 0; p < 3; p++) begin
      for (int h = 1; h <= 3; h++) begin
        step3(5'b00010);
        check($sformatf("solo%0d_h%0d", p, h), dut3_out(), pk(5'b00010, 3'd1, 1'b1, 1'b0, 8'(h)));
      end
      step3(5'b00010);
      check($sformatf("solo%0d_gap", p), dut3_out(), pk(5'b00000, 3'd7, 1'b0, 1'b1, 8'd0));
    end
    step3(5'b00000);
    check("solo_idle", dut3_out(), idle_exp);
    step3(5'b00000);
    check("solo_idle2", dut3_out(), idle_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
